hazard_ctrl: RTL

- Pipeline control unit that drives the stall/flush inputs of the four pipeline latches (fetch/decode, decode/exec, exec/mem, mem/wb) and the PC enable.
- Detects instruction-fetch waits, data-memory waits, load-use hazards, taken branches/jumps resolved in EX, and halt reaching MEM.
- The latches give stall priority over flush, so this block never relies on both being asserted at once. It owns a small FSM and a pending-flush register to resolve that ordering.

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: drives stall/flush for the four pipeline latches and the PC enable.
// Define HAZARD_PERF_CNT_EN to add saturating stall_cycles / flush_events counters.
module hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_access,
    input  logic             mem_halt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             em_flush,
    output logic             mw_stall,
    output logic             mw_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`else
    output logic             halted
`endif
);

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        StRun,
        StDwait,
        StHalted
    } state_e;

    state_e r_state;
    state_e w_state_d;
    logic   r_pend_flush;
    logic   w_pend_flush_d;

    logic   w_dwait;
    logic   w_lu;

    assign w_dwait = mem_access & ~dhit;
    assign w_lu    = ex_memread & (ex_rd != '0) &
                     ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= StRun;
            r_pend_flush <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pend_flush <= w_pend_flush_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d      = r_state;
        w_pend_flush_d = r_pend_flush;
        unique case (r_state)
            StRun, StDwait: begin
                if (w_dwait) begin
                    w_state_d = StDwait;
                    // A redirect seen while stalled is replayed once the memory frees up.
                    w_pend_flush_d = r_pend_flush | branch_taken;
                end else begin
                    w_state_d = mem_halt ? StHalted : StRun;
                    if (ihit && (branch_taken || r_pend_flush)) begin
                        w_pend_flush_d = 1'b0;
                    end
                end
            end
            StHalted: begin
                w_state_d = StHalted;
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_en    = 1'b0;
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_stall = 1'b0;
        de_flush = 1'b0;
        em_stall = 1'b0;
        em_flush = 1'b0;
        mw_stall = 1'b0;
        mw_flush = 1'b0;
        if (nRST) begin
            unique case (r_state)
                StHalted: begin
                    fd_stall = 1'b1;
                    de_stall = 1'b1;
                    em_stall = 1'b1;
                    mw_flush = 1'b1;
                end
                default: begin
                    if (w_dwait) begin
                        fd_stall = 1'b1;
                        de_stall = 1'b1;
                        em_stall = 1'b1;
                        mw_flush = 1'b1;
                    end else if (!ihit && branch_taken) begin
                        // Hold the branch in EX until the redirected fetch can start.
                        fd_stall = 1'b1;
                        de_stall = 1'b1;
                        em_flush = 1'b1;
                    end else if (!ihit) begin
                        fd_flush = 1'b1;
                    end else if (branch_taken || r_pend_flush) begin
                        pc_en    = 1'b1;
                        fd_flush = 1'b1;
                        de_flush = 1'b1;
                    end else if (w_lu) begin
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            endcase
        end
    end

    assign halted = (r_state == StHalted);

`ifdef HAZARD_PERF_CNT_EN
    cnt_t r_stall_cycles;
    cnt_t r_flush_events;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else if (r_state != StHalted) begin
            if (!pc_en && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + cnt_t'(1);
            end
            if (fd_flush && de_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + cnt_t'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule
